// File: rtl/fetch_controller.sv
// Instruction fetch/dispatch sequencer: fetches the hi/lo instruction words,
// hands the instruction to execute, owns the pc and stops on the HALT opcode.
package fetch_pkg;
    localparam int WORD_SIZE   = 8;
    localparam int OPCODE_BITS = 5;
endpackage

module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                     ADDR_BITS   = 8,
    parameter logic [ADDR_BITS-1:0]   RESET_PC    = '0,
    parameter logic [OPCODE_BITS-1:0] HALT_OPCODE = 5'h1F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] inst_hi,
    output logic [WORD_SIZE-1:0] inst_lo,
    output logic                 inst_valid,
    output logic                 exec_start,
    input  logic                 exec_done,
    input  logic                 pc_load,
    input  logic [ADDR_BITS-1:0] pc_target,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_HI,
        S_FETCH_LO,
        S_DISPATCH,
        S_EXEC_WAIT,
        S_HALT
    } state_t;

    localparam logic [ADDR_BITS-1:0] PC_STEP = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t state;
    logic   is_halt;

    assign is_halt = (inst_hi[WORD_SIZE-1 -: OPCODE_BITS] == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            inst_hi <= '0;
            inst_lo <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH_HI;
                end
                S_FETCH_HI: begin
                    if (mem_ack) begin
                        inst_hi <= mem_rdata;
                        pc      <= pc + PC_STEP;
                        state   <= S_FETCH_LO;
                    end
                end
                S_FETCH_LO: begin
                    if (mem_ack) begin
                        inst_lo <= mem_rdata;
                        pc      <= pc + PC_STEP;
                        state   <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    state <= is_halt ? S_HALT : S_EXEC_WAIT;
                end
                S_EXEC_WAIT: begin
                    // pc already points past the low word, so no jump means fall through
                    if (exec_done) begin
                        if (pc_load) pc <= pc_target;
                        state <= S_FETCH_HI;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = (state == S_FETCH_HI) || (state == S_FETCH_LO);
    assign mem_addr   = pc;
    assign inst_valid = (state == S_DISPATCH) || (state == S_EXEC_WAIT);
    assign exec_start = (state == S_DISPATCH) && !is_halt;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: memory/execute responders plus a
// monitor comparing fetch addresses and dispatched instructions to queues.
module tb_fetch_controller;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] pc;
    } inst_exp_t;

    typedef struct {
        int         dly;
        bit         stray;
        bit         load;
        logic [7:0] tgt;
    } exec_cfg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] inst_hi;
    logic [7:0] inst_lo;
    logic       inst_valid;
    logic       exec_start;
    logic       exec_done;
    logic       pc_load;
    logic [7:0] pc_target;
    logic [7:0] pc;
    logic       halted;

    logic       resp_ack = 1'b0;
    logic [7:0] resp_rdata = 8'hEE;
    logic       force_ack = 1'b0;
    logic       resp_done = 1'b0;
    logic       resp_load = 1'b0;
    logic [7:0] resp_tgt = 8'h00;
    logic       man_done = 1'b0;
    logic       man_load = 1'b0;
    logic [7:0] man_tgt = 8'h00;

    bit mem_en = 1'b0;
    bit exec_en = 1'b0;
    int ack_delay = 0;

    logic [7:0] mem [0:255];

    logic [7:0] addr_q [$];
    inst_exp_t  inst_q [$];
    exec_cfg_t  cfg_q  [$];

    int n_chk = 0;
    int n_pass = 0;
    int n_start = 0;

    assign mem_ack   = resp_ack | force_ack;
    assign mem_rdata = force_ack ? 8'h99 : resp_rdata;
    assign exec_done = resp_done | man_done;
    assign pc_load   = resp_load | man_load;
    assign pc_target = (man_done | man_load) ? man_tgt : resp_tgt;

    fetch_controller dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_hi    (inst_hi),
        .inst_lo    (inst_lo),
        .inst_valid (inst_valid),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    function automatic logic [35:0] out_vec();
        return {pc, mem_addr, inst_hi, inst_lo,
                mem_req, inst_valid, exec_start, halted};
    endfunction

    // Memory responder: acks after ack_delay wait cycles, garbage otherwise
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en && mem_req) begin
                if (wcnt >= ack_delay) begin
                    resp_ack   = 1'b1;
                    resp_rdata = mem[mem_addr];
                    wcnt       = 0;
                end else begin
                    resp_ack   = 1'b0;
                    resp_rdata = 8'hEE;
                    wcnt++;
                end
            end else begin
                resp_ack   = 1'b0;
                resp_rdata = 8'hEE;
                wcnt       = 0;
            end
        end
    end

    // Execute responder: config per dispatched instruction from cfg_q
    initial begin
        int        cnt;
        bit        pending;
        exec_cfg_t cur;
        cnt = 0;
        pending = 1'b0;
        cur = '{0, 1'b0, 1'b0, 8'h00};
        forever begin
            @(posedge clk);
            #1;
            if (!exec_en) begin
                pending   = 1'b0;
                resp_done = 1'b0;
                resp_load = 1'b0;
            end else if (exec_start) begin
                pending = 1'b1;
                cnt     = 0;
                if (cfg_q.size() > 0) cur = cfg_q.pop_front();
                else cur = '{0, 1'b0, 1'b0, 8'h00};
                resp_done = 1'b0;
                resp_load = 1'b0;
            end else if (pending) begin
                if (cnt == cur.dly) begin
                    resp_done = 1'b1;
                    resp_load = cur.load;
                    resp_tgt  = cur.tgt;
                    pending   = 1'b0;
                end else begin
                    resp_done = 1'b0;
                    resp_load = cur.stray;
                    resp_tgt  = 8'h77;
                    cnt++;
                end
            end else begin
                resp_done = 1'b0;
                resp_load = 1'b0;
                resp_tgt  = 8'h00;
            end
        end
    end

    // Monitor
    initial begin
        inst_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && mem_req) begin
                if (addr_q.size() == 0) fail("fetch_unexpected");
                else if (mem_ack) chk("fetch_addr", mem_addr, addr_q.pop_front());
                else chk("hold_addr", mem_addr, addr_q[0]);
            end
            if (!rst && exec_start) begin
                n_start++;
                if (inst_q.size() == 0) begin
                    fail("start_unexpected");
                end else begin
                    e = inst_q.pop_front();
                    chk("inst_hi", inst_hi, e.hi);
                    chk("inst_lo", inst_lo, e.lo);
                    chk("dispatch_pc", pc, e.pc);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!exec_start && n < 100);
        if (!exec_start) fail("start_timeout");
    endtask

    task automatic wait_halt(input int bound);
        int k;
        k = 0;
        while (!halted && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!halted) fail("halt_timeout");
    endtask

    initial begin
        int n;
        int m;

        // Basic instruction then HALT; ack and done in the first possible cycle
        clear_mem();
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'hF8;
        mem[8'h03] = 8'h00;
        mem_en = 1'b1;
        exec_en = 1'b1;
        ack_delay = 0;
        do_reset();
        @(negedge clk);
        chk("reset_outputs", out_vec(), 36'h0);
        n_start = 0;
        addr_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        inst_q.push_back('{8'h11, 8'h22, 8'h02});
        cfg_q.push_back('{0, 1'b0, 1'b0, 8'h00});
        @(posedge clk);
        #1 run = 1'b1;
        wait_start(n);
        chk("start_cycle", n, 3);
        run = 1'b0;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!(inst_valid && inst_hi == 8'hF8) && m < 50);
        chk("halt_dispatch_no_start", {inst_valid, exec_start}, 2'b10);
        @(negedge clk);
        chk("halted_next_cycle", {halted, inst_valid}, 2'b10);
        chk("start_pulses", n_start, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            run = ~run;
            force_ack = 1'b1;
            @(negedge clk);
            chk("halt_sticky", {halted, mem_req, exec_start, inst_valid, pc, inst_hi},
                {4'b1000, 8'h04, 8'hF8});
        end
        force_ack = 1'b0;
        run = 1'b0;

        // Slow memory, stray pc_load, jumps and a fetch straddling the pc wrap
        clear_mem();
        mem[8'h00] = 8'h33;
        mem[8'h01] = 8'h44;
        mem[8'h02] = 8'h55;
        mem[8'h03] = 8'h66;
        mem[8'h40] = 8'h12;
        mem[8'h41] = 8'h34;
        mem[8'hFF] = 8'h56;
        mem[8'h50] = 8'hF8;
        mem[8'h51] = 8'h00;
        ack_delay = 3;
        do_reset();
        n_start = 0;
        addr_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h41,
                   8'hFF, 8'h00, 8'h50, 8'h51};
        inst_q.push_back('{8'h33, 8'h44, 8'h02});
        inst_q.push_back('{8'h55, 8'h66, 8'h04});
        inst_q.push_back('{8'h12, 8'h34, 8'h42});
        inst_q.push_back('{8'h56, 8'h33, 8'h01});
        cfg_q.push_back('{0, 1'b0, 1'b0, 8'h00});
        cfg_q.push_back('{2, 1'b1, 1'b1, 8'h40});
        cfg_q.push_back('{0, 1'b0, 1'b1, 8'hFF});
        cfg_q.push_back('{1, 1'b0, 1'b1, 8'h50});
        @(posedge clk);
        #1 run = 1'b1;
        wait_start(n);
        chk("start_cycle_slow", n, 9);
        run = 1'b0;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!mem_req && m < 20);
        chk("instr_cycles_slow", n + m - 1, 10);
        wait_halt(400);
        chk("halt_pc", pc, 8'h52);
        chk("start_pulses_b", n_start, 4);
        chk("addr_q_drained", addr_q.size(), 0);
        chk("inst_q_drained", inst_q.size(), 0);
        chk("cfg_q_drained", cfg_q.size(), 0);

        // Async reset in EXEC_WAIT, then a late exec_done in IDLE
        clear_mem();
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        ack_delay = 0;
        exec_en = 1'b0;
        do_reset();
        addr_q = '{8'h00, 8'h01};
        inst_q.push_back('{8'h11, 8'h22, 8'h02});
        @(posedge clk);
        #1 run = 1'b1;
        wait_start(n);
        @(negedge clk);
        chk("in_exec_wait", {inst_valid, exec_start}, 2'b10);
        #2 rst = 1'b1;
        #1 chk("async_rst_exec", out_vec(), 36'h0);
        run = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        man_done = 1'b1;
        man_load = 1'b1;
        man_tgt = 8'h40;
        repeat (2) @(posedge clk);
        #1 man_done = 1'b0;
        man_load = 1'b0;
        @(negedge clk);
        chk("late_done_ignored", {pc, mem_req, inst_valid}, 10'h0);

        // Async reset in FETCH_LO, then a late mem_ack in IDLE
        ack_delay = 2;
        mem_en = 1'b1;
        addr_q = '{8'h00, 8'h01};
        @(posedge clk);
        #1 run = 1'b1;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!(mem_req && mem_addr == 8'h01) && m < 30);
        chk("in_fetch_lo", {mem_req, inst_valid, inst_hi}, {2'b10, 8'h11});
        #2 rst = 1'b1;
        #1 chk("async_rst_fetch_lo", out_vec(), 36'h0);
        addr_q.delete();
        run = 1'b0;
        mem_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", {pc, inst_hi, inst_lo, mem_req}, 25'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequencing FSM in front of the instruction decoder.
- Fetches the two instruction words (high then low) from instruction memory through a req/ack handshake, holds them stable on inst_hi/inst_lo for the decoder, and hands the instruction to the execute stage with a start/done handshake.
- Owns the program counter, applies taken jumps reported by the execute stage, and stops on the HALT opcode.
- Widths come from the shared config: WORD_SIZE, OPCODE_BITS.

Parameters:
- ADDR_BITS, 8, width of the program counter and of mem_addr.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 5'h1F, opcode value (inst_hi top OPCODE_BITS bits) that halts the machine.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  level; leaves IDLE when high.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_BITS  read address, always equal to pc.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  WORD_SIZE  read data.
- inst_hi  out  WORD_SIZE  registered high instruction word, to decoder.
- inst_lo  out  WORD_SIZE  registered low instruction word, to decoder.
- inst_valid  out  1  inst_hi/inst_lo hold a complete instruction.
- exec_start  out  1  one-cycle pulse: execute stage may begin.
- exec_done  in  1  execute stage finished.
- pc_load  in  1  jump taken; qualified by exec_done.
- pc_target  in  ADDR_BITS  jump destination.
- pc  out  ADDR_BITS  current program counter.
- halted  out  1  high in HALT state.

Behaviour:

Reset (async, immediate, regardless of state):
- State = IDLE; pc = RESET_PC; inst_hi = inst_lo = 0.
- inst_valid, exec_start, mem_req, halted = 0.
- Reset mid-handshake abandons the transaction; a late mem_ack or exec_done is ignored in IDLE.

Outputs:
- mem_req, exec_start, inst_valid and halted decode combinationally from state.
- mem_addr = pc at all times.

States:
- IDLE: no outputs asserted. run=1 -> FETCH_HI at the next edge.
- FETCH_HI: mem_req=1. mem_rdata is sampled only in a mem_ack cycle. On mem_ack: inst_hi <= mem_rdata, pc <= pc+1, -> FETCH_LO. Otherwise remain, with mem_req held high.
- FETCH_LO: same as FETCH_HI, but loads inst_lo, -> DISPATCH.
- DISPATCH: inst_valid=1.
  - If inst_hi[WORD_SIZE-1 -: OPCODE_BITS] == HALT_OPCODE: exec_start stays 0, -> HALT.
  - Else: exec_start=1 for exactly this cycle, -> EXEC_WAIT.
  - exec_done in DISPATCH is ignored.
- EXEC_WAIT: inst_valid=1, inst_hi/inst_lo held stable. On exec_done:
  - pc <= pc_load ? pc_target : pc (already points at the next instruction).
  - -> FETCH_HI.
  - pc_load without exec_done is ignored.
- HALT: halted=1, inst_valid=0. Exit only by rst; run is ignored.

Rules and boundary conditions:
- run is sampled only in IDLE; deasserting run later does not stop execution.
- mem_ack outside the FETCH states is ignored.
- pc increments modulo 2^ADDR_BITS: 0xFF -> 0x00 at ADDR_BITS=8. A fetch pair may straddle the wrap: hi at 0xFF, lo at 0x00.
- inst_hi/inst_lo change only on an acked fetch in their own state. inst_lo is stale during FETCH_LO, with inst_valid=0.

Latency:
- Minimum of 4 cycles per instruction, with mem_ack and exec_done both returned in the first possible cycle: FETCH_HI, FETCH_LO, DISPATCH, EXEC_WAIT.
- Each extra wait cycle on mem_ack or exec_done adds 1 cycle.

Test Plan:
- Reset then run=1, memory {0x00:0x11, 0x01:0x22}, ack same cycle. Required:
  - mem_addr 0x00 then 0x01.
  - inst_hi=0x11, inst_lo=0x22.
  - exec_start pulses exactly once, in cycle 3 after leaving IDLE.
  - pc=0x02 after exec_done.
- mem_ack delayed 3 cycles on each word: mem_req and mem_addr held stable while waiting; mem_rdata garbage in non-ack cycles never captured; instruction completes in 10 cycles.
- exec_done with pc_load=1, pc_target=0x40: next mem_addr=0x40. Also pc_load=1 pulsed without exec_done: pc unchanged.
- pc preset near wrap (RESET_PC=0xFF): hi fetched from 0xFF, lo from 0x00, then pc=0x01.
- Instruction with inst_hi=0xF8 (opcode 0x1F): no exec_start; halted=1 from the next cycle; run toggling and mem_ack have no effect until rst.
- rst asserted asynchronously mid-EXEC_WAIT and mid-FETCH_LO: all outputs reach reset values immediately without a clock edge; a late exec_done/mem_ack after release is ignored in IDLE.
